pfd_tdc: RTL
============

Name: pfd_tdc

Overview:
- Synchronous phase-frequency detector with time-to-digital measurement.
- Samples the reference edge and the feedback (divided VCO) edge on a fast sampling clock.
- Drives charge-pump style up/dn levels and outputs a signed phase error, in clk cycles, once per comparison window.
- Includes cycle-slip detection and a lock detector. It is the parametrised successor of the analog-style PFD in the PLL loop and feeds a digital loop filter.

Parameters:
- CNT_W, 8: error/counter width, signed two's complement. Saturation magnitude SAT = 2^(CNT_W-1)-1.
- SYNC_STAGES, 2: synchroniser flops on ref_in and fb_in. Minimum 2.
- LOCK_TOL, 2: maximum |err| counted as "in lock".
- LOCK_CNT, 16: consecutive in-tolerance windows required to assert locked.
- MIN_PULSE, 2: minimum up/dn overlap width in cycles. Used only with the optional feature.

Ports:
- clk  in  1  sampling clock; must be faster than ref_in.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous clear: FSM, counter and lock state.
- ref_in  in  1  reference clock, asynchronous to clk.
- fb_in  in  1  feedback clock, asynchronous to clk.
- up  out  1  high while ref leads.
- dn  out  1  high while fb leads.
- err  out  CNT_W  signed phase error; positive means ref leads.
- err_valid  out  1  one-cycle strobe; err is valid in that cycle.
- cycle_slip  out  1  one-cycle strobe on a repeated leading edge.
- locked  out  1  lock indicator.

Behaviour:
- Reset (rst, or clr at a clk edge): all outputs 0, err=0, FSM in IDLE, cnt=0, lock counter=0, synchroniser flops 0.
- Edge detect: rising edge of the last sync stage (re = ref edge, fe = fb edge). Pin-to-re latency is SYNC_STAGES+1 clk cycles.
- FSM states: IDLE, REF_LEAD, FB_LEAD.
- IDLE:
  - re only -> REF_LEAD, cnt<=1.
  - fe only -> FB_LEAD, cnt<=1.
  - re & fe -> err<=0, err_valid pulse, stay IDLE.
- REF_LEAD (up=1, dn=0):
  - Each cycle cnt<=cnt+1, saturating at SAT.
  - fe -> err<=+cnt, err_valid, IDLE.
  - re without fe -> cycle_slip pulse, err<=+SAT, err_valid, stay REF_LEAD, cnt<=1.
  - re & fe -> err<=+cnt, err_valid, stay REF_LEAD, cnt<=1.
- FB_LEAD (dn=1, up=0): mirror of REF_LEAD, with err negated (-cnt, -SAT).
- Saturation: cnt never wraps. err is never -2^(CNT_W-1).
- err holds its last value between strobes. up and dn are registered outputs of the FSM state, updated on the same edge as the state.
- Lock detector:
  - On each err_valid with |err|<=LOCK_TOL and no cycle_slip, lock counter +1, saturating at LOCK_CNT.
  - locked=1 when the lock counter equals LOCK_CNT.
  - Any err_valid with |err|>LOCK_TOL, or any cycle_slip, sets the lock counter to 0 and locked to 0 in the same cycle.
- clr and rst mid-window: measurement discarded, no err_valid issued.

Optional Feature:
- Macro: PFD_TDC_ANTI_DEADZONE_EN.
- Defined:
  - On every window close (including the simultaneous-edge zero-error case), up and dn are both forced high for MIN_PULSE cycles.
  - The forced pulse overlaps any new lead state.
  - err, err_valid and the lock logic are unaffected.
- Undefined: up/dn reflect FSM state only; a zero-error window produces no pulse.

Decomposition:
- Package pfd_tdc_pkg:
  - state enum (IDLE, REF_LEAD, FB_LEAD).
  - function sat_max(CNT_W).
  - localparam defaults.
- Sub-module pfd_lock_det: lock counter and locked flag. Inputs err, err_valid, cycle_slip, clr. Parameters LOCK_TOL, LOCK_CNT.
- Synchroniser stays inline as a SYNC_STAGES-deep shift register per input.

Test Plan:
- Reset/idle: hold rst, then release with no edges -> all outputs 0 indefinitely.
- Ref leads by 5 clk cycles, both inputs periodic at 40 clk -> err=+5 and err_valid once per period; up high 5 cycles, dn 0.
- Fb leads by 3 cycles -> err=-3; dn high 3 cycles. Simultaneous edges -> err=0 with no up/dn pulse. With PFD_TDC_ANTI_DEADZONE_EN: up=dn=1 for 2 cycles.
- Two ref edges, no fb, CNT_W=8 -> cycle_slip pulse, err=+127, locked drops to 0.
- Ref 300 cycles ahead, CNT_W=8 -> err=+127 (saturated, no wrap).
- 16 windows with err in [-2,+2] -> locked rises after the 16th strobe. Next err=+3 -> locked=0 in the same cycle. Assert clr mid-REF_LEAD -> no err_valid and state IDLE.

Source files
------------

// File: rtl/pfd_tdc_pkg.sv
// pfd_tdc_pkg: shared FSM state type, default parameters and saturation helper
// Items: state_t (IDLE, REF_LEAD, FB_LEAD), *_DEF parameter defaults, sat_max(w)
package pfd_tdc_pkg;

    typedef enum logic [1:0] {IDLE, REF_LEAD, FB_LEAD} state_t;

    localparam int CNT_W_DEF       = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int LOCK_TOL_DEF    = 2;
    localparam int LOCK_CNT_DEF    = 16;
    localparam int MIN_PULSE_DEF   = 2;

    // Largest positive value of a w-bit two's complement number
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/pfd_lock_det.sv
// pfd_lock_det: counts consecutive in-tolerance phase errors and flags lock
// Ports: clk, rst (async, active-high), clr (sync clear),
//        err/err_valid/cycle_slip (measurement strobe from the PFD), locked (lock flag)
module pfd_lock_det import pfd_tdc_pkg::*; #(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int LOCK_TOL = LOCK_TOL_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic signed [CNT_W-1:0] err,
    input  logic                    err_valid,
    input  logic                    cycle_slip,
    output logic                    locked
);
    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam logic [LW-1:0] FULL = LW'(LOCK_CNT);
    localparam logic [CNT_W-1:0] TOL = CNT_W'(LOCK_TOL);
    logic [LW-1:0] lcnt;
    logic [CNT_W-1:0] mag;
    logic bad;
    // err never reaches the most negative code, so the negation cannot overflow
    assign mag = err[CNT_W-1] ? -err : err;
    assign bad = err_valid && (cycle_slip || mag > TOL);
    // A bad strobe drops lock in the same cycle, before the counter clears
    assign locked = (lcnt == FULL) && !bad;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lcnt <= '0;
        else if (clr || bad)
            lcnt <= '0;
        else if (err_valid && lcnt != FULL)
            lcnt <= lcnt + 1'b1;
    end
endmodule

// File: rtl/pfd_tdc.sv
// pfd_tdc: synchronous phase-frequency detector with time-to-digital phase error
// Ports: clk (sampling clock), rst (async, active-high), clr (sync clear),
//        ref_in/fb_in (async reference and feedback clocks), up/dn (charge-pump levels),
//        err/err_valid (signed phase error in clk cycles + strobe), cycle_slip, locked
// Option: define PFD_TDC_ANTI_DEADZONE_EN to force up=dn=1 for MIN_PULSE cycles per window close
module pfd_tdc import pfd_tdc_pkg::*; #(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int LOCK_TOL    = LOCK_TOL_DEF,
    parameter int LOCK_CNT    = LOCK_CNT_DEF,
    parameter int MIN_PULSE   = MIN_PULSE_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    ref_in,
    input  logic                    fb_in,
    output logic                    up,
    output logic                    dn,
    output logic signed [CNT_W-1:0] err,
    output logic                    err_valid,
    output logic                    cycle_slip,
    output logic                    locked
);
    localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_max(CNT_W));
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    state_t state;
    logic [SYNC_STAGES-1:0] ref_s, fb_s;
    logic ref_d, fb_d, re, fe, frc;
    logic [CNT_W-1:0] cnt, cnt_inc;
    assign re = ref_s[SYNC_STAGES-1] & ~ref_d;
    assign fe = fb_s[SYNC_STAGES-1] & ~fb_d;
    assign cnt_inc = (cnt == SAT) ? cnt : cnt + ONE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            ref_s <= '0;
            fb_s  <= '0;
            ref_d <= 1'b0;
            fb_d  <= 1'b0;
        end else begin
            ref_s <= {ref_s[SYNC_STAGES-2:0], ref_in};
            fb_s  <= {fb_s[SYNC_STAGES-2:0], fb_in};
            ref_d <= ref_s[SYNC_STAGES-1];
            fb_d  <= fb_s[SYNC_STAGES-1];
        end
    end
`ifdef PFD_TDC_ANTI_DEADZONE_EN
    localparam int PW = $clog2(MIN_PULSE + 1);
    logic [PW-1:0] pcnt;
    logic close;
    // Any strobe closes a window: both-edge match in IDLE, or any edge while leading
    assign close = (state == IDLE) ? (re & fe) : (re | fe);
    assign frc = close || pcnt != '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pcnt <= '0;
        else if (clr)
            pcnt <= '0;
        else if (close)
            pcnt <= PW'(MIN_PULSE - 1);
        else if (pcnt != '0)
            pcnt <= pcnt - 1'b1;
    end
`else
    // Forcing disabled: constant-false keeps the parameter referenced
    assign frc = (MIN_PULSE < 0);
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            state      <= IDLE;
            cnt        <= '0;
            err        <= '0;
            err_valid  <= 1'b0;
            cycle_slip <= 1'b0;
            up         <= 1'b0;
            dn         <= 1'b0;
        end else begin
            err_valid  <= 1'b0;
            cycle_slip <= 1'b0;
            case (state)
                IDLE: begin
                    up <= frc;
                    dn <= frc;
                    if (re && fe) begin
                        err       <= '0;
                        err_valid <= 1'b1;
                    end else if (re) begin
                        state <= REF_LEAD;
                        cnt   <= ONE;
                        up    <= 1'b1;
                    end else if (fe) begin
                        state <= FB_LEAD;
                        cnt   <= ONE;
                        dn    <= 1'b1;
                    end
                end
                REF_LEAD: begin
                    up  <= 1'b1;
                    dn  <= frc;
                    cnt <= cnt_inc;
                    if (fe) begin
                        err       <= cnt;
                        err_valid <= 1'b1;
                        if (re) begin
                            cnt <= ONE;
                        end else begin
                            state <= IDLE;
                            up    <= frc;
                        end
                    end else if (re) begin
                        cycle_slip <= 1'b1;
                        err        <= SAT;
                        err_valid  <= 1'b1;
                        cnt        <= ONE;
                    end
                end
                FB_LEAD: begin
                    up  <= frc;
                    dn  <= 1'b1;
                    cnt <= cnt_inc;
                    if (re) begin
                        err       <= '0 - cnt;
                        err_valid <= 1'b1;
                        if (fe) begin
                            cnt <= ONE;
                        end else begin
                            state <= IDLE;
                            dn    <= frc;
                        end
                    end else if (fe) begin
                        cycle_slip <= 1'b1;
                        err        <= '0 - SAT;
                        err_valid  <= 1'b1;
                        cnt        <= ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    pfd_lock_det #(
        .CNT_W   (CNT_W),
        .LOCK_TOL(LOCK_TOL),
        .LOCK_CNT(LOCK_CNT)
    ) u_lock (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .err       (err),
        .err_valid (err_valid),
        .cycle_slip(cycle_slip),
        .locked    (locked)
    );
endmodule
